trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/core_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 21 ++
 rtl/trap_ctrl.sv | 120 ++++++++++++
 tb/tb_trap_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: exception/interrupt cause codes, trap FSM states and mtvec modes.
package core_pkg;

  localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'h0000_0000;
  localparam logic [31:0] CAUSE_ILLEGAL_INSN     = 32'h0000_0002;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'h0000_0003;
  localparam logic [31:0] CAUSE_ECALL_M          = 32'h0000_000B;

  localparam logic [31:0] CAUSE_M_SW_INT    = 32'h8000_0003;
  localparam logic [31:0] CAUSE_M_TIMER_INT = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_EXT_INT   = 32'h8000_000B;

  // Bit positions shared by the raw lines, the synchronizer bank and mie_i.
  localparam int IRQ_MSI = 0;
  localparam int IRQ_MTI = 1;
  localparam int IRQ_MEI = 2;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  function automatic logic [31:0] mtvec_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous interrupt line.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap controller: takes interrupts, exceptions and MRET at write-back, then flushes and redirects.
// Define TRAP_VECTORED_EN to enable vectored interrupt targets when mtvec_i[1:0] selects vectored mode.
module trap_ctrl
  import core_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        xint_meip_i,
  input  logic        xint_mtip_i,
  input  logic        xint_msip_i,
  input  logic        mstatus_mie_i,
  input  logic [2:0]  mie_i,
  input  logic        wb_valid_i,
  input  logic [31:0] wb_pc_i,
  input  logic        exc_taken_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        flush_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        int_taken_o,
  output logic [31:0] int_cause_o,
  output logic [31:0] int_epc_o
);

  logic [2:0]  sync_q;
  logic [2:0]  pend;
  logic        int_req;
  logic [31:0] sel_cause;
  logic [31:0] base;
  logic [31:0] int_target;
  logic [31:0] target_d;
  logic [31:0] target_q;
  trap_state_e state_q;
  trap_state_e state_d;

  sync_2ff u_sync_mei (.clk_i(clk_i), .rst_i(rst_i), .d_i(xint_meip_i), .q_o(sync_q[IRQ_MEI]));
  sync_2ff u_sync_mti (.clk_i(clk_i), .rst_i(rst_i), .d_i(xint_mtip_i), .q_o(sync_q[IRQ_MTI]));
  sync_2ff u_sync_msi (.clk_i(clk_i), .rst_i(rst_i), .d_i(xint_msip_i), .q_o(sync_q[IRQ_MSI]));

  assign pend    = sync_q & mie_i & {3{mstatus_mie_i}};
  assign int_req = wb_valid_i & (|pend);
  assign base    = mtvec_base(mtvec_i);

  // MSI outranks MTI even though its cause code is lower.
  always_comb begin
    if (pend[IRQ_MEI])      sel_cause = CAUSE_M_EXT_INT;
    else if (pend[IRQ_MSI]) sel_cause = CAUSE_M_SW_INT;
    else                    sel_cause = CAUSE_M_TIMER_INT;
  end

`ifdef TRAP_VECTORED_EN
  assign int_target = (mtvec_i[1:0] == MTVEC_MODE_VECTORED)
                    ? base + {26'd0, sel_cause[3:0], 2'b00}
                    : base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];
  assign int_target = base;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Only IDLE accepts events; anything seen in FLUSH/REDIRECT belongs to flushed instructions.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    unique case (state_q)
      IDLE: begin
        if (int_req) begin
          state_d  = FLUSH;
          target_d = int_target;
        end else if (exc_taken_i) begin
          state_d  = FLUSH;
          target_d = base;
        end else if (mret_i) begin
          state_d  = FLUSH;
          target_d = mepc_i;
        end
      end
      FLUSH:    state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    flush_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'd0;
    int_taken_o   = 1'b0;
    int_cause_o   = 32'd0;
    int_epc_o     = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (int_req) begin
          int_taken_o = 1'b1;
          int_cause_o = sel_cause;
          int_epc_o   = wb_pc_i;
        end
      end
      FLUSH: flush_o = 1'b1;
      REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = target_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a randomized run against a cycle model.
// Honours TRAP_VECTORED_EN the same way the design does.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        xint_meip_i, xint_mtip_i, xint_msip_i;
  logic        mstatus_mie_i;
  logic [2:0]  mie_i;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic        exc_taken_i, mret_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        flush_o, redirect_o, int_taken_o;
  logic [31:0] redirect_pc_o, int_cause_o, int_epc_o;

  int checks = 0;
  int errors = 0;

  trap_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .xint_meip_i(xint_meip_i), .xint_mtip_i(xint_mtip_i), .xint_msip_i(xint_msip_i),
    .mstatus_mie_i(mstatus_mie_i), .mie_i(mie_i),
    .wb_valid_i(wb_valid_i), .wb_pc_i(wb_pc_i),
    .exc_taken_i(exc_taken_i), .mret_i(mret_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .int_taken_o(int_taken_o), .int_cause_o(int_cause_o), .int_epc_o(int_epc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    xint_meip_i = 1'b0; xint_mtip_i = 1'b0; xint_msip_i = 1'b0;
    mstatus_mie_i = 1'b1; mie_i = 3'b111;
    wb_valid_i = 1'b0; wb_pc_i = 32'd0;
    exc_taken_i = 1'b0; mret_i = 1'b0;
    mtvec_i = 32'd0; mepc_i = 32'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1'b1;
    #3;
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flush got %0b want 0", flush_o); end
    checks++; if (redirect_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect got %0b want 0", redirect_o); end
    checks++; if (int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_int_taken got %0b want 0", int_taken_o); end
    cyc(); cyc();
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (redirect_pc_o !== 32'd0) begin errors++; $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc_o); end
  endtask

  task automatic test_exception();
    cyc();
    mtvec_i = 32'h0000_0100; exc_taken_i = 1'b1;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_flush_early got %0b want 0", flush_o); end
    cyc(); exc_taken_i = 1'b0;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("[TB] FAIL exc_flush got %0b want 1", flush_o); end
    checks++; if (redirect_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_redirect_early got %0b want 0", redirect_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (redirect_o !== 1'b1) begin errors++; $display("[TB] FAIL exc_redirect got %0b want 1", redirect_o); end
    checks++; if (redirect_pc_o !== 32'h0000_0100) begin errors++; $display("[TB] FAIL exc_redirect_pc got %h want 00000100", redirect_pc_o); end
    checks++; if (int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL exc_int_taken got %0b want 0", int_taken_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (redirect_o !== 1'b0 || redirect_pc_o !== 32'd0) begin errors++; $display("[TB] FAIL exc_after got %0b/%h want 0/0", redirect_o, redirect_pc_o); end
  endtask

  task automatic test_mret();
    cyc();
    mtvec_i = 32'h0000_0100; mepc_i = 32'h0000_2004; mret_i = 1'b1;
    cyc(); mret_i = 1'b0;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("[TB] FAIL mret_flush got %0b want 1", flush_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h0000_2004) begin errors++; $display("[TB] FAIL mret_redirect got %0b/%h want 1/00002004", redirect_o, redirect_pc_o); end
    cyc();
  endtask

  task automatic test_interrupt_priority();
    cyc();
    mtvec_i = 32'h0000_0100; wb_valid_i = 1'b1; wb_pc_i = 32'h80;
    xint_meip_i = 1'b1; xint_mtip_i = 1'b1;
    @(negedge clk_i);
    checks++; if (int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_sync0 got %0b want 0", int_taken_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_sync1 got %0b want 0", int_taken_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (int_taken_o !== 1'b1) begin errors++; $display("[TB] FAIL irq_taken got %0b want 1", int_taken_o); end
    checks++; if (int_cause_o !== 32'h8000_000B) begin errors++; $display("[TB] FAIL irq_cause got %h want 8000000b", int_cause_o); end
    checks++; if (int_epc_o !== 32'h80) begin errors++; $display("[TB] FAIL irq_epc got %h want 00000080", int_epc_o); end
    cyc(); xint_meip_i = 1'b0; xint_mtip_i = 1'b0;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b1 || int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_flush got %0b/%0b want 1/0", flush_o, int_taken_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (redirect_pc_o !== 32'h0000_0100 || int_taken_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_redirect got %h/%0b want 00000100/0", redirect_pc_o, int_taken_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (int_taken_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("[TB] FAIL irq_after got %0b/%0b want 0/0", int_taken_o, flush_o); end
    idle_inputs();
  endtask

  task automatic test_vectored();
    logic [31:0] want;
`ifdef TRAP_VECTORED_EN
    want = 32'h0000_021C;
`else
    want = 32'h0000_0200;
`endif
    cyc();
    mtvec_i = 32'h0000_0201; wb_valid_i = 1'b1; wb_pc_i = 32'h44; xint_mtip_i = 1'b1;
    cyc(); cyc();
    @(negedge clk_i);
    checks++; if (int_taken_o !== 1'b1 || int_cause_o !== 32'h8000_0007) begin errors++; $display("[TB] FAIL vec_cause got %0b/%h want 1/80000007", int_taken_o, int_cause_o); end
    cyc(); xint_mtip_i = 1'b0;
    cyc();
    @(negedge clk_i);
    checks++; if (redirect_o !== 1'b1 || redirect_pc_o !== want) begin errors++; $display("[TB] FAIL vec_target got %0b/%h want 1/%h", redirect_o, redirect_pc_o, want); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_priority_ignore();
    cyc();
    mtvec_i = 32'h0000_0300; mepc_i = 32'h0000_4000; exc_taken_i = 1'b1; mret_i = 1'b1;
    cyc(); exc_taken_i = 1'b0; mret_i = 1'b0;
    cyc(); mret_i = 1'b1; mepc_i = 32'h0000_5000;
    @(negedge clk_i);
    checks++; if (redirect_pc_o !== 32'h0000_0300) begin errors++; $display("[TB] FAIL exc_over_mret got %h want 00000300", redirect_pc_o); end
    cyc(); mret_i = 1'b0;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b0 || redirect_o !== 1'b0) begin errors++; $display("[TB] FAIL mret_in_redirect got %0b/%0b want 0/0", flush_o, redirect_o); end
    cyc();
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b0) begin errors++; $display("[TB] FAIL mret_in_redirect2 got %0b want 0", flush_o); end
    mstatus_mie_i = 1'b0; xint_msip_i = 1'b1; wb_valid_i = 1'b1; wb_pc_i = 32'h90;
    for (int i = 0; i < 5; i++) begin
      cyc();
      @(negedge clk_i);
      checks++; if (int_taken_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("[TB] FAIL mie_off got %0b/%0b want 0/0", int_taken_o, flush_o); end
    end
    xint_msip_i = 1'b0;
    cyc(); cyc(); cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_flush();
    cyc();
    mtvec_i = 32'h0000_0100; exc_taken_i = 1'b1;
    cyc(); exc_taken_i = 1'b0;
    @(negedge clk_i);
    checks++; if (flush_o !== 1'b1) begin errors++; $display("[TB] FAIL rstflush_pre got %0b want 1", flush_o); end
    rst_i = 1'b1;
    #1;
    checks++; if ({flush_o, redirect_o, int_taken_o} !== 3'b000) begin errors++; $display("[TB] FAIL rstflush_ctrl got %b want 000", {flush_o, redirect_o, int_taken_o}); end
    checks++; if (redirect_pc_o !== 32'd0 || int_cause_o !== 32'd0 || int_epc_o !== 32'd0) begin errors++; $display("[TB] FAIL rstflush_data got %h/%h/%h want 0/0/0", redirect_pc_o, int_cause_o, int_epc_o); end
    cyc(); cyc();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checks++; if (redirect_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("[TB] FAIL rstflush_after got %0b/%0b want 0/0", redirect_o, flush_o); end
      cyc();
    end
  endtask

  // Model: a line is visible as pending two cycles after it is driven; after an
  // accepted event the block spends one cycle flushing and one redirecting.
  task automatic test_random();
    localparam int N = 400;
    logic [2:0]  hist [N];
    logic [2:0]  x, sync, p;
    int          phase, nxt;
    logic [31:0] tgt, base, e_cause, e_epc, e_pc;
    logic        e_int, e_flush, e_red, vec;
    idle_inputs();
    rst_i = 1'b1;
    cyc(); cyc();
    rst_i = 1'b0;
    phase = 0; tgt = 0; x = 3'b000;
    for (int c = 0; c < N; c++) begin
      if (c > 0) cyc();
      for (int k = 0; k < 3; k++) if ($urandom_range(0, 7) == 0) x[k] = ~x[k];
      xint_meip_i = x[2]; xint_mtip_i = x[1]; xint_msip_i = x[0];
      hist[c] = x;
      mie_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      mstatus_mie_i = ($urandom_range(0, 7) != 0);
      wb_valid_i = ($urandom_range(0, 3) != 0);
      wb_pc_i = $urandom;
      exc_taken_i = ($urandom_range(0, 4) == 0);
      mret_i = ($urandom_range(0, 4) == 0);
      mtvec_i = {($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom), 8'($urandom)};
      mepc_i = $urandom;
      @(negedge clk_i);
      sync = (c >= 2) ? hist[c-2] : 3'b000;
      p = sync & mie_i & {3{mstatus_mie_i}};
      base = mtvec_i & 32'hFFFF_FFFC;
`ifdef TRAP_VECTORED_EN
      vec = (mtvec_i[1:0] == 2'b01);
`else
      vec = 1'b0;
`endif
      e_int = 0; e_cause = 0; e_epc = 0; e_flush = 0; e_red = 0; e_pc = 0; nxt = phase;
      if (phase == 0) begin
        if (wb_valid_i && p != 3'b000) begin
          e_int = 1;
          e_cause = p[2] ? 32'h8000_000B : (p[0] ? 32'h8000_0003 : 32'h8000_0007);
          e_epc = wb_pc_i;
          tgt = vec ? base + 4 * (e_cause & 32'hF) : base;
          nxt = 2;
        end else if (exc_taken_i) begin
          tgt = base; nxt = 2;
        end else if (mret_i) begin
          tgt = mepc_i; nxt = 2;
        end
      end else if (phase == 2) begin
        e_flush = 1; nxt = 1;
      end else begin
        e_red = 1; e_pc = tgt; nxt = 0;
      end
      checks++; if (int_taken_o !== e_int) begin errors++; $display("[TB] FAIL rnd_int_taken c=%0d got %0b want %0b", c, int_taken_o, e_int); end
      checks++; if (int_cause_o !== e_cause) begin errors++; $display("[TB] FAIL rnd_cause c=%0d got %h want %h", c, int_cause_o, e_cause); end
      checks++; if (int_epc_o !== e_epc) begin errors++; $display("[TB] FAIL rnd_epc c=%0d got %h want %h", c, int_epc_o, e_epc); end
      checks++; if (flush_o !== e_flush) begin errors++; $display("[TB] FAIL rnd_flush c=%0d got %0b want %0b", c, flush_o, e_flush); end
      checks++; if (redirect_o !== e_red) begin errors++; $display("[TB] FAIL rnd_redirect c=%0d got %0b want %0b", c, redirect_o, e_red); end
      checks++; if (redirect_pc_o !== e_pc) begin errors++; $display("[TB] FAIL rnd_redirect_pc c=%0d got %h want %h", c, redirect_pc_o, e_pc); end
      phase = nxt;
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_exception();
    test_mret();
    test_interrupt_priority();
    test_vectored();
    test_priority_ignore();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
